sr_cmd_driver: RTL and testbench

- Command-side counterpart to the game's SR flip-flop cells.
- Takes raw player/game request levels (set_req, clr_req), synchronizes them, edge-detects them and arbitrates between them.
- Emits clean, width-controlled 2-bit SR commands (10 = set, 01 = clear, 00 = hold) that drive an SR flip-flop cell such as a game-over or shield latch.
- Guarantees the illegal code 11 is never produced, enforces a hold-off window between commands, and keeps a mirror of the downstream latch state for status and verification.

---
 rtl/sr_cmd_driver.sv | 172 +++++++++++++++++
 tb/tb_sr_cmd_driver.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : sr_cmd_driver
// Purpose  : Turns raw set/clear request levels into clean 2-bit SR commands
//            for a downstream SR flip-flop cell. Requests are synchronized,
//            rising-edge detected and arbitrated (clear wins). Each command is
//            held for PULSE_CYCLES, then followed by HOLDOFF_CYCLES of SR=00.
//            The code 11 is never produced.
// Ports    : CLK      - system clock
//            RST      - synchronous, active-high reset
//            set_req  - asynchronous level, rising edge requests set
//            clr_req  - asynchronous level, rising edge requests clear
//            SR       - registered command, bit1 = S, bit0 = R
//            busy     - high while a pulse or hold-off is in progress
//            q_mirror - predicted Q of the driven SR flip-flop
//            conflict - one-cycle pulse when set and clear events coincide
//            drop_cnt - saturating count of cycles with events discarded
// Revision : 1.0 - initial release
// ============================================================================
module sr_cmd_driver #(
  parameter int SYNC_STAGES    = 2,  // must be >= 2
  parameter int PULSE_CYCLES   = 1,  // must be >= 1
  parameter int HOLDOFF_CYCLES = 4   // 0 allowed
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       set_req,
  input  logic       clr_req,
  output logic [1:0] SR,
  output logic       busy,
  output logic       q_mirror,
  output logic       conflict,
  output logic [7:0] drop_cnt
);

  // One counter serves both the pulse and the hold-off phases, so it is sized
  // for the longer of the two (it only ever counts up to length-1).
  localparam int c_CNT_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

  localparam logic [c_CNT_W-1:0] c_PULSE_LAST = c_CNT_W'(PULSE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST  =
      c_CNT_W'((HOLDOFF_CYCLES > 0) ? (HOLDOFF_CYCLES - 1) : 0);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_PULSE   = 2'd1;
  localparam logic [1:0] c_HOLDOFF = 2'd2;

  localparam logic [1:0] c_SR_SET  = 2'b10;
  localparam logic [1:0] c_SR_CLR  = 2'b01;
  localparam logic [1:0] c_SR_HOLD = 2'b00;

  // --------------------------------------------------------------------------
  // Synchronizers and rising-edge detection. The history flops run every
  // cycle independent of the FSM, so a held level never produces a second
  // event, and an event seen while busy is simply lost (and counted).
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_set_sync;
  logic [SYNC_STAGES-1:0] r_clr_sync;
  logic                   r_set_prev;
  logic                   r_clr_prev;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_set_sync <= '0;
      r_clr_sync <= '0;
      r_set_prev <= 1'b0;
      r_clr_prev <= 1'b0;
    end else begin
      r_set_sync <= {r_set_sync[SYNC_STAGES-2:0], set_req};
      r_clr_sync <= {r_clr_sync[SYNC_STAGES-2:0], clr_req};
      r_set_prev <= r_set_sync[SYNC_STAGES-1];
      r_clr_prev <= r_clr_sync[SYNC_STAGES-1];
    end
  end

  logic w_set_evt;
  logic w_clr_evt;
  logic w_any_evt;

  assign w_set_evt = r_set_sync[SYNC_STAGES-1] & ~r_set_prev;
  assign w_clr_evt = r_clr_sync[SYNC_STAGES-1] & ~r_clr_prev;
  assign w_any_evt = w_set_evt | w_clr_evt;

  // --------------------------------------------------------------------------
  // Command FSM, drop counter and latch mirror
  // --------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [1:0]         r_sr;
  logic               r_q;
  logic               r_conflict;
  logic [7:0]         r_drop;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= c_IDLE;
      r_cnt      <= '0;
      r_sr       <= c_SR_HOLD;
      r_q        <= 1'b0;
      r_conflict <= 1'b0;
      r_drop     <= 8'd0;
    end else begin
      r_conflict <= 1'b0;

      case (r_state)
        c_IDLE: begin
          r_cnt <= '0;
          if (w_clr_evt) begin
            // Clear wins a tie; the tie itself is flagged alongside the code.
            r_state    <= c_PULSE;
            r_sr       <= c_SR_CLR;
            r_conflict <= w_set_evt;
          end else if (w_set_evt) begin
            r_state <= c_PULSE;
            r_sr    <= c_SR_SET;
          end else begin
            r_sr <= c_SR_HOLD;
          end
        end

        c_PULSE: begin
          // r_sr keeps its code until the last pulse cycle has been shown.
          if (r_cnt == c_PULSE_LAST) begin
            r_sr    <= c_SR_HOLD;
            r_cnt   <= '0;
            r_state <= (HOLDOFF_CYCLES > 0) ? c_HOLDOFF : c_IDLE;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end

        c_HOLDOFF: begin
          r_sr <= c_SR_HOLD;
          if (r_cnt == c_HOLD_LAST) begin
            r_cnt   <= '0;
            r_state <= c_IDLE;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end

        default: begin
          r_state <= c_IDLE;
          r_cnt   <= '0;
          r_sr    <= c_SR_HOLD;
        end
      endcase

      // A set+clear pair dropped in the same cycle counts once.
      if ((r_state != c_IDLE) && w_any_evt && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'd1;
      end

      // Same rule as the driven cell, so the mirror trails SR by one edge.
      case (r_sr)
        c_SR_SET: r_q <= 1'b1;
        c_SR_CLR: r_q <= 1'b0;
        default:  r_q <= r_q;
      endcase
    end
  end

  assign SR       = r_sr;
  assign busy     = (r_state != c_IDLE);
  assign q_mirror = r_q;
  assign conflict = r_conflict;
  assign drop_cnt = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_sr_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_cmd_driver
// Purpose  : Self-checking bench for sr_cmd_driver. Two instances share the
//            same request stimulus: one with default timing (1-cycle pulse,
//            4-cycle hold-off) and one with a 3-cycle pulse and a 1000-cycle
//            hold-off. A timeline model predicts every output each cycle, and
//            directed scenarios add hand-computed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_cmd_driver;

  localparam int S = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       set_req = 1'b0;
  logic       clr_req = 1'b0;

  logic [1:0] d_sr   [2];
  logic       d_busy [2];
  logic       d_q    [2];
  logic       d_conf [2];
  logic [7:0] d_drop [2];

  always #5 CLK = ~CLK;

  sr_cmd_driver #(
    .SYNC_STAGES   (S),
    .PULSE_CYCLES  (1),
    .HOLDOFF_CYCLES(4)
  ) u_dut0 (
    .CLK     (CLK),
    .RST     (RST),
    .set_req (set_req),
    .clr_req (clr_req),
    .SR      (d_sr[0]),
    .busy    (d_busy[0]),
    .q_mirror(d_q[0]),
    .conflict(d_conf[0]),
    .drop_cnt(d_drop[0])
  );

  sr_cmd_driver #(
    .SYNC_STAGES   (S),
    .PULSE_CYCLES  (3),
    .HOLDOFF_CYCLES(1000)
  ) u_dut1 (
    .CLK     (CLK),
    .RST     (RST),
    .set_req (set_req),
    .clr_req (clr_req),
    .SR      (d_sr[1]),
    .busy    (d_busy[1]),
    .q_mirror(d_q[1]),
    .conflict(d_conf[1]),
    .drop_cnt(d_drop[1])
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int pulse_len(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int hold_len(input int d);
    return (d == 0) ? 4 : 1000;
  endfunction

  // --------------------------------------------------------------------------
  // Timeline model: the request history is a delay line of input samples;
  // a command issued at edge t shows its code on edges t..t+P-1 and keeps the
  // block busy on edges t..t+P+H-1. Events arriving while busy are dropped.
  // --------------------------------------------------------------------------
  bit         started = 0;
  int         cyc;
  bit         hs[$];
  bit         hc[$];
  bit         issued [2];
  int         t_iss  [2];
  logic [1:0] code   [2];
  logic [1:0] m_sr   [2];
  logic       m_q    [2];
  logic       m_busy [2];
  logic       m_conf [2];
  int         m_drop [2];

  always @(posedge CLK) begin
    bit se, ce, busy_before;
    logic nq;
    started = 1;
    if (RST) begin
      cyc = 0;
      hs.delete();
      hc.delete();
      for (int i = 0; i <= S; i++) begin
        hs.push_back(1'b0);
        hc.push_back(1'b0);
      end
      for (int d = 0; d < 2; d++) begin
        issued[d] = 0;
        t_iss[d]  = 0;
        code[d]   = 2'b00;
        m_sr[d]   = 2'b00;
        m_q[d]    = 1'b0;
        m_busy[d] = 1'b0;
        m_conf[d] = 1'b0;
        m_drop[d] = 0;
      end
    end else begin
      // hs[i] holds the input sampled i+1 edges ago
      se = hs[S-1] && !hs[S];
      ce = hc[S-1] && !hc[S];
      for (int d = 0; d < 2; d++) begin
        busy_before = issued[d] && ((cyc - 1 - t_iss[d]) < pulse_len(d) + hold_len(d));
        nq = (m_sr[d] == 2'b10) ? 1'b1 : (m_sr[d] == 2'b01) ? 1'b0 : m_q[d];
        m_conf[d] = 1'b0;
        if (se || ce) begin
          if (!busy_before) begin
            issued[d] = 1;
            t_iss[d]  = cyc;
            code[d]   = ce ? 2'b01 : 2'b10;
            m_conf[d] = se && ce;
          end else if (m_drop[d] < 255) begin
            m_drop[d]++;
          end
        end
        m_sr[d]   = (issued[d] && (cyc - t_iss[d]) < pulse_len(d)) ? code[d] : 2'b00;
        m_busy[d] = issued[d] && ((cyc - t_iss[d]) < pulse_len(d) + hold_len(d));
        m_q[d]    = nq;
      end
      hs.push_front(set_req);
      hc.push_front(clr_req);
      void'(hs.pop_back());
      void'(hc.pop_back());
      cyc++;
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("model_sr%0d", d),       d_sr[d],   m_sr[d]);
        chk($sformatf("model_busy%0d", d),     d_busy[d], m_busy[d]);
        chk($sformatf("model_q%0d", d),        d_q[d],    m_q[d]);
        chk($sformatf("model_conflict%0d", d), d_conf[d], m_conf[d]);
        chk($sformatf("model_drop%0d", d),     d_drop[d], m_drop[d]);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus. After step(n) the bench sits 1 time unit past edge
  // n-1 (edges numbered from 0 after reset release).
  // --------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RST     = 1'b1;
    set_req = 1'b0;
    clr_req = 1'b0;
    step(2);
    RST = 1'b0;
  endtask

  int n10;
  int nz;
  int first_nz;

  initial begin
    // Quiet after reset
    step(1);
    do_reset();
    step(10);
    chk("idle_sr", d_sr[0], 2'b00);
    chk("idle_busy", d_busy[0], 1'b0);
    chk("idle_drop", d_drop[0], 8'd0);

    // Held set level: one command at edge 2, busy through edge 6
    do_reset();
    set_req = 1'b1;
    step(3);
    chk("set_sr_e2", d_sr[0], 2'b10);
    chk("set_busy_e2", d_busy[0], 1'b1);
    step(1);
    chk("set_sr_e3", d_sr[0], 2'b00);
    chk("set_q_e3", d_q[0], 1'b1);
    step(3);
    chk("set_busy_e6", d_busy[0], 1'b1);
    step(1);
    chk("set_busy_e7", d_busy[0], 1'b0);
    nz = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (d_sr[0] != 2'b00) nz++;
    end
    chk("set_no_retrigger", nz, 0);

    // Simultaneous set and clear
    do_reset();
    set_req = 1'b1;
    clr_req = 1'b1;
    step(3);
    chk("tie_sr_e2", d_sr[0], 2'b01);
    chk("tie_conflict_e2", d_conf[0], 1'b1);
    step(1);
    chk("tie_conflict_e3", d_conf[0], 1'b0);
    chk("tie_q_e3", d_q[0], 1'b0);

    // Clear during hold-off is dropped, a later clear goes through
    do_reset();
    set_req = 1'b1;
    step(1);
    set_req = 1'b0;
    step(3);
    clr_req = 1'b1;
    step(3);
    chk("drop_cnt_e6", d_drop[0], 8'd1);
    chk("drop_q_e6", d_q[0], 1'b1);
    clr_req = 1'b0;
    step(2);
    clr_req = 1'b1;
    step(3);
    chk("clr_sr_e11", d_sr[0], 2'b01);
    step(1);
    chk("clr_q_e12", d_q[0], 1'b0);
    clr_req = 1'b0;

    // Long hold-off on instance 1: 300 events saturate drop_cnt
    do_reset();
    n10 = 0;
    set_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (d_sr[1] == 2'b10) n10++;
    end
    set_req = 1'b0;
    for (int i = 0; i < 300; i++) begin
      set_req = (i % 2 == 1);
      clr_req = (i % 2 == 0);
      step(1);
      if (d_sr[1] == 2'b10) n10++;
    end
    set_req = 1'b0;
    clr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (d_sr[1] == 2'b10) n10++;
    end
    chk("sat_drop", d_drop[1], 8'd255);
    chk("sat_pulse_len", n10, 3);
    chk("sat_busy", d_busy[1], 1'b1);

    // Reset in the middle of a pulse, request held through release
    do_reset();
    set_req = 1'b1;
    step(3);
    chk("rst_sr_before", d_sr[0], 2'b10);
    RST = 1'b1;
    step(1);
    chk("rst_sr", d_sr[0], 2'b00);
    chk("rst_busy", d_busy[0], 1'b0);
    chk("rst_q", d_q[0], 1'b0);
    step(1);
    RST = 1'b0;
    nz = 0;
    first_nz = -1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (d_sr[0] != 2'b00) begin
        nz++;
        if (first_nz < 0) first_nz = i;
      end
    end
    chk("rst_one_cmd", nz, 1);
    chk("rst_cmd_edge", first_nz, 2);
    set_req = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
